inst_encoder: RTL and testbench

- Packs decoded instruction fields (kind, register numbers, 64-bit signed immediate) into 32-bit LEGv8 instruction words. It is the inverse of the immediate sign extender.
- Sits between the testbench/boot loader stream and the instruction memory write port. It emits words with a word address and a valid/ready handshake.
- Range-checks every immediate so that sign-extending the emitted word reproduces the input immediate exactly. Out-of-range or unknown requests are dropped and counted.

---
 rtl/inst_encoder.sv | 113 +++++++++++
 tb/tb_inst_encoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded LEGv8 instruction fields into 32-bit words
// for the instruction memory write port. It is the inverse of the immediate
// sign extender. Immediates that would not survive a sign-extend round trip,
// and unknown kinds, are dropped and counted.
//
// Ports:
//   clk, reset           clock (rising edge), async active-low reset
//   in_valid/in_ready    request handshake (accept = in_valid && in_ready)
//   in_kind              0=LDUR 1=STUR 2=CBZ 3=CBNZ 4=ADDI 5..7=illegal
//   in_rt, in_rn, in_imm register fields and 64-bit signed immediate
//   in_last              final request of a program
//   out_valid/out_ready  output handshake
//   out_word, out_addr   encoded word and its word address
//   out_last             in_last of the emitted word
//   rej_pulse            one-cycle pulse after a rejected accept
//   rej_count            saturating reject counter
module inst_encoder #(
    parameter int          ADDR_W    = 8,
    parameter int          ERR_W     = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rn,
    input  logic [63:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              rej_pulse,
    output logic [ERR_W-1:0]  rej_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    // An immediate fits an N-bit field when bits [63:N-1] are all copies
    // of the field's sign bit.
    logic fits9, fits12, fits19;
    assign fits9  = (&in_imm[63:8])  | ~(|in_imm[63:8]);
    assign fits12 = (&in_imm[63:11]) | ~(|in_imm[63:11]);
    assign fits19 = (&in_imm[63:18]) | ~(|in_imm[63:18]);

    logic [31:0] enc_word;
    logic        legal;

    always_comb begin
        enc_word = '0;
        legal    = 1'b0;
        case (in_kind)
            3'd0: begin
                enc_word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rt};
                legal    = fits9;
            end
            3'd1: begin
                enc_word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rt};
                legal    = fits9;
            end
            3'd2: begin
                enc_word = {8'b10110100, in_imm[18:0], in_rt};
                legal    = fits19;
            end
            3'd3: begin
                enc_word = {8'b10110101, in_imm[18:0], in_rt};
                legal    = fits19;
            end
            3'd4: begin
                enc_word = {10'b1001000100, in_imm[11:0], in_rn, in_rt};
                legal    = fits12;
            end
            default: ;
        endcase
    end

    logic accept, out_hs;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_addr  <= BASE;
            out_last  <= 1'b0;
            rej_pulse <= 1'b0;
            rej_count <= '0;
        end else begin
            rej_pulse <= accept && !legal;
            if (accept && !legal && rej_count != {ERR_W{1'b1}})
                rej_count <= rej_count + ERR_W'(1);

            // out_addr is the running counter: a word loaded in the same
            // cycle as a handshake picks up the already-advanced address.
            if (out_hs)
                out_addr <= out_last ? BASE : out_addr + ADDR_W'(1);

            if (accept && legal) begin
                out_valid <= 1'b1;
                out_word  <= enc_word;
                out_last  <= in_last;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

    localparam int AW   = 2;
    localparam int EW   = 8;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_kind = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rn = '0;
    logic [63:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [AW-1:0] out_addr;
    logic        out_last;
    logic        rej_pulse;
    logic [EW-1:0] rej_count;

    inst_encoder #(.ADDR_W(AW), .ERR_W(EW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rt(in_rt), .in_rn(in_rn), .in_imm(in_imm), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_addr(out_addr), .out_last(out_last),
        .rej_pulse(rej_pulse), .rej_count(rej_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int field_bits(input logic [2:0] kind);
        case (kind)
            3'd0, 3'd1: return 9;
            3'd2, 3'd3: return 19;
            3'd4:       return 12;
            default:    return 0;
        endcase
    endfunction

    // Legal when the signed value lies within [-2^(N-1), 2^(N-1)-1].
    function automatic bit m_legal(input logic [2:0] kind, input logic [63:0] imm);
        int n;
        longint v, lim;
        n = field_bits(kind);
        if (n == 0) return 1'b0;
        v   = longint'(imm);
        lim = longint'(1) << (n - 1);
        return (v >= -lim) && (v < lim);
    endfunction

    function automatic logic [31:0] m_enc(input logic [2:0] kind, input logic [4:0] rt,
                                          input logic [4:0] rn, input logic [63:0] imm);
        longint f, r, t, w;
        f = longint'(imm) & ((longint'(1) << field_bits(kind)) - 1);
        r = longint'(rn);
        t = longint'(rt);
        case (kind)
            3'd0:    w = 64'hF840_0000 + f * 4096 + r * 32 + t;
            3'd1:    w = 64'hF800_0000 + f * 4096 + r * 32 + t;
            3'd2:    w = 64'hB400_0000 + f * 32 + t;
            3'd3:    w = 64'hB500_0000 + f * 32 + t;
            3'd4:    w = 64'h9100_0000 + f * 1024 + r * 32 + t;
            default: w = 0;
        endcase
        return 32'(w);
    endfunction

    logic        m_valid, m_last, m_rej;
    logic [31:0] m_word;
    int          m_addr, m_cnt;

    wire m_rdy = !m_valid || out_ready;
    wire m_acc = in_valid && m_rdy;
    wire m_ok  = m_legal(in_kind, in_imm);
    wire m_hs  = m_valid && out_ready;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0; m_word <= '0; m_last <= 1'b0;
            m_rej <= 1'b0; m_addr <= BASE; m_cnt <= 0;
        end else begin
            m_rej <= m_acc && !m_ok;
            if (m_acc && !m_ok && m_cnt < (1 << EW) - 1) m_cnt <= m_cnt + 1;
            if (m_hs) m_addr <= m_last ? BASE : (m_addr + 1) % (1 << AW);
            if (m_acc && m_ok) begin
                m_valid <= 1'b1;
                m_word  <= m_enc(in_kind, in_rt, in_rn, in_imm);
                m_last  <= in_last;
            end else if (m_hs) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("in_ready", in_ready, m_rdy);
            chk("out_valid", out_valid, m_valid);
            chk("out_addr", out_addr, m_addr);
            chk("rej_pulse", rej_pulse, m_rej);
            chk("rej_count", rej_count, m_cnt);
            if (m_valid) begin
                chk("out_word", out_word, m_word);
                chk("out_last", out_last, m_last);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        #2 reset = 1'b1;
    endtask

    // Called between a negedge and the next posedge; returns at negedge+1
    // after the accepting edge.
    task automatic put(input logic [2:0] k, input logic [4:0] rt, input logic [4:0] rn,
                       input longint imm, input logic last);
        int n = 0;
        in_valid = 1'b1; in_kind = k; in_rt = rt; in_rn = rn;
        in_imm = 64'(imm); in_last = last;
        while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) chk("accept_timeout", 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    logic signed [18:0] cb_field;
    longint              sx;
    longint              rimm, lim;
    int                  rk, nb;

    initial begin
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_out_last", out_last, 0);
        chk("rst_rej_pulse", rej_pulse, 0);
        chk("rst_rej_count", rej_count, 0);
        #1 reset = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // LDUR
        put(3'd0, 5'd1, 5'd2, -8, 1'b0);
        chk("ldur_word", out_word, 32'hF85F8041);
        chk("ldur_addr", out_addr, 0);
        chk("ldur_valid", out_valid, 1);

        // ADDI at the top of its range, then one past
        do_reset();
        put(3'd4, 5'd3, 5'd4, 2047, 1'b0);
        chk("addi_word", out_word, 32'h911FFC83);
        put(3'd4, 5'd3, 5'd4, 2048, 1'b0);
        chk("addi_rej_pulse", rej_pulse, 1);
        chk("addi_rej_count", rej_count, 1);
        chk("addi_rej_novalid", out_valid, 0);
        @(negedge clk); #1;
        chk("rej_pulse_one_cycle", rej_pulse, 0);

        // CBZ / CBNZ
        do_reset();
        put(3'd2, 5'd5, 5'd0, -1, 1'b0);
        chk("cbz_word", out_word, 32'hB4FFFFE5);
        chk("cbz_addr", out_addr, 0);
        cb_field = out_word[23:5];
        sx = longint'(cb_field);
        chk("cbz_roundtrip", 64'(sx), 64'(-1));
        put(3'd3, 5'd5, 5'd0, 262144, 1'b0);
        chk("cbnz_rej", rej_pulse, 1);
        chk("cbnz_novalid", out_valid, 0);

        // Stall: out_ready 0,0 then 1
        do_reset();
        out_ready = 1'b0;
        put(3'd4, 5'd1, 5'd1, 5, 1'b0);
        chk("stall_w0", out_word, 32'h91001421);
        in_valid = 1'b1; in_imm = 64'd6;
        #1 chk("stall_in_ready", in_ready, 0);
        @(negedge clk); #1;
        chk("stall_hold_word", out_word, 32'h91001421);
        chk("stall_hold_addr", out_addr, 0);
        chk("stall_in_ready2", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("stall_w1", out_word, 32'h91001821);
        chk("stall_a1", out_addr, 1);
        put(3'd4, 5'd1, 5'd1, 7, 1'b0);
        chk("stall_w2", out_word, 32'h91001C21);
        chk("stall_a2", out_addr, 2);
        put(3'd4, 5'd1, 5'd1, 8, 1'b0);
        chk("stall_w3", out_word, 32'h91002021);
        chk("stall_a3", out_addr, 3);

        // Address wrap and reload on last
        do_reset();
        for (int i = 0; i < 5; i++) begin
            put(3'd4, 5'd2, 5'd2, i, (i == 4));
            chk("wrap_addr", out_addr, i % 4);
        end
        chk("wrap_last", out_last, 1);
        put(3'd0, 5'd1, 5'd1, 0, 1'b0);
        chk("reload_addr", out_addr, BASE);
        put(3'd0, 5'd1, 5'd1, 1, 1'b0);
        chk("after_reload_addr", out_addr, 1);

        // Rejected last must not reload the address
        do_reset();
        put(3'd1, 5'd1, 5'd1, 1, 1'b0);
        put(3'd1, 5'd1, 5'd1, 2, 1'b0);
        put(3'd5, 5'd1, 5'd1, 0, 1'b1);
        put(3'd1, 5'd1, 5'd1, 3, 1'b0);
        chk("rej_last_addr", out_addr, 2);

        // Saturation
        do_reset();
        for (int i = 0; i < 300; i++) put(3'(5 + i % 3), 5'd0, 5'd0, 0, 1'b0);
        chk("sat_count", rej_count, 255);
        chk("sat_pulse", rej_pulse, 1);

        // Reset mid-transfer
        do_reset();
        put(3'd6, 5'd0, 5'd0, 0, 1'b0);
        out_ready = 1'b0;
        put(3'd1, 5'd1, 5'd1, 4, 1'b0);
        chk("mid_valid_before", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_valid_async", out_valid, 0);
        chk("mid_count", rej_count, 0);
        chk("mid_addr", out_addr, BASE);
        @(negedge clk); #1 reset = 1'b1;
        out_ready = 1'b1;

        // Randomized stream against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            rk = int'($urandom_range(0, 7));
            nb = (rk <= 1) ? 9 : (rk <= 3) ? 19 : 12;
            lim = longint'(1) << (nb - 1);
            case ($urandom_range(0, 3))
                0: rimm = longint'($urandom_range(0, 32'(2 * lim - 1))) - lim;
                1: case ($urandom_range(0, 3))
                       0: rimm = lim - 1;
                       1: rimm = lim;
                       2: rimm = -lim;
                       default: rimm = -lim - 1;
                   endcase
                2: rimm = longint'({$urandom(), $urandom()});
                default: rimm = longint'($urandom_range(0, 600)) - 300;
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            in_kind   = 3'(rk);
            in_rt     = 5'($urandom);
            in_rn     = 5'($urandom);
            in_imm    = 64'(rimm);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
